// File: rtl/decode_issue_if.sv
// Fetch-to-decode handshake: fetch presents an instruction (or a flush),
// and decode answers with in_ready.
interface decode_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        flush;

  modport master (
    output in_valid,
    output in_instr,
    output flush,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    input  flush,
    output in_ready
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes 16-bit instructions, blocks read-after-write hazards
// with a per-register pending-write scoreboard, and registers ALU controls for execute.
module decode_issue #(
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_issue_if.slave     fetch,
  output logic [2:0]        rf_raddr1,
  output logic [2:0]        rf_raddr2,
  output logic [2:0]        rf_raddr3,
  input  logic [15:0]       rf_rdata1,
  input  logic [15:0]       rf_rdata2,
  input  logic [15:0]       rf_rdata3,
  input  logic              wb_valid,
  input  logic [2:0]        wb_rd,
  output logic [11:0]       alusignals,
  output logic [15:0]       op1,
  output logic [15:0]       op2,
  output logic [4:0]        immx,
  output logic              isimmediate,
  output logic [15:0]       stdata,
  output logic [15:0]       instrout,
  output logic              illegal
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_LD  = 4'd1,  OP_ST  = 4'd2,  OP_SUB = 4'd3,
    OP_MUL = 4'd4,  OP_CMP = 4'd5,  OP_MOV = 4'd6,  OP_OR  = 4'd7,
    OP_AND = 4'd8,  OP_NOT = 4'd9,  OP_LSL = 4'd10, OP_LSR = 4'd11,
    OP_NOP = 4'd15
  } opcode_e;

  localparam logic [2:0] FLAGS_REG = 3'd7;

  logic [3:0] opcode;
  logic       i_bit;
  logic [2:0] rd, rs1, rs2;

  assign opcode = fetch.in_instr[15:12];
  assign i_bit  = fetch.in_instr[11];
  assign rd     = fetch.in_instr[10:8];
  assign rs1    = fetch.in_instr[7:5];
  assign rs2    = fetch.in_instr[4:2];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign rf_raddr3 = rd;

  // Instruction class decode
  logic       use_rs1, use_rs2, use_rd;
  logic       has_dest, is_nop, reserved;
  logic [2:0] dest;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    has_dest = 1'b0;
    is_nop   = 1'b0;
    reserved = 1'b0;
    dest     = rd;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_LSL, OP_LSR: begin
        use_rs1  = 1'b1;
        use_rs2  = ~i_bit;
        has_dest = 1'b1;
      end
      OP_CMP: begin
        use_rs1  = 1'b1;
        use_rs2  = ~i_bit;
        has_dest = 1'b1;
        dest     = FLAGS_REG;
      end
      OP_MOV: begin
        use_rs2  = ~i_bit;
        has_dest = 1'b1;
      end
      OP_LD, OP_NOT: begin
        use_rs1  = 1'b1;
        has_dest = 1'b1;
      end
      OP_ST: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_NOP:  is_nop   = 1'b1;
      default: reserved = 1'b1;
    endcase
  end

  // Scoreboard: number of in-flight writes per register, saturating at 3
  logic [1:0] pend_q [8];
  logic [1:0] pend_d [8];

  logic hazard, accept, issue;

  always_comb begin
    hazard = (use_rs1  && (pend_q[rs1] != 2'd0)) ||
             (use_rs2  && (pend_q[rs2] != 2'd0)) ||
             (use_rd   && (pend_q[rd]  != 2'd0)) ||
             (has_dest && (pend_q[dest] == 2'd3));
  end

  assign fetch.in_ready = rst_n & ~fetch.flush & ~hazard;
  assign accept         = fetch.in_valid & fetch.in_ready;
  assign issue          = accept & ~reserved & ~is_nop;

  // Decrement first so an increment on the same register nets to no change.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid && (pend_q[wb_rd] != 2'd0)) begin
      pend_d[wb_rd] = pend_q[wb_rd] - 2'd1;
    end
    if (issue && has_dest) begin
      pend_d[dest] = pend_d[dest] + 2'd1;
    end
  end

  // Registered ALU-side outputs
  logic [11:0] alu_d, alu_q;
  logic [15:0] op1_d, op1_q;
  logic [15:0] op2_d, op2_q;
  logic [4:0]  immx_d, immx_q;
  logic        isimm_d, isimm_q;
  logic [15:0] stdata_d, stdata_q;
  logic [15:0] instr_d, instr_q;
  logic        illegal_d, illegal_q;

  always_comb begin
    alu_d     = '0;
    op1_d     = '0;
    op2_d     = '0;
    immx_d    = '0;
    isimm_d   = 1'b0;
    stdata_d  = '0;
    instr_d   = NOP_INSTR;
    illegal_d = accept & reserved;
    if (issue) begin
      alu_d    = 12'd1 << opcode;
      op1_d    = rf_rdata1;
      op2_d    = rf_rdata2;
      stdata_d = rf_rdata3;
      immx_d   = fetch.in_instr[4:0];
      isimm_d  = i_bit | (opcode == OP_LD) | (opcode == OP_ST);
      instr_d  = fetch.in_instr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the scoreboard must be reset as a whole; stale counts would
      // stall fetch forever after a mid-stream reset.
      for (int r = 0; r < 8; r++) begin
        pend_q[r] <= 2'd0;
      end
      alu_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      immx_q    <= '0;
      isimm_q   <= 1'b0;
      stdata_q  <= '0;
      instr_q   <= NOP_INSTR;
      illegal_q <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        pend_q[r] <= pend_d[r];
      end
      alu_q     <= alu_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      immx_q    <= immx_d;
      isimm_q   <= isimm_d;
      stdata_q  <= stdata_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  assign alusignals  = alu_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign immx        = immx_q;
  assign isimmediate = isimm_q;
  assign stdata      = stdata_q;
  assign instrout    = instr_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed vector table for the hazard/saturation/flush
// corners, then randomized traffic checked against a counting scoreboard model.
module tb_decode_issue;

  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_raddr3;
  logic [15:0] rf_rdata1, rf_rdata2, rf_rdata3;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [11:0] alusignals;
  logic [15:0] op1, op2, stdata, instrout;
  logic [4:0]  immx;
  logic        isimmediate, illegal;

  logic [15:0] rf [8];

  always #5 clk = ~clk;

  decode_issue_if fif ();

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign rf_rdata3 = rf[rf_raddr3];

  decode_issue #(.NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch       (fif),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_raddr3   (rf_raddr3),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .rf_rdata3   (rf_rdata3),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .alusignals  (alusignals),
    .op1         (op1),
    .op2         (op2),
    .immx        (immx),
    .isimmediate (isimmediate),
    .stdata      (stdata),
    .instrout    (instrout),
    .illegal     (illegal)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending-write count per register, from the ISA rules.
  int pend_m [8];

  typedef struct {
    bit legal;
    bit src1, src2, src3;
    int dest;
  } dec_t;

  typedef struct {
    logic [11:0] alu;
    logic [15:0] op1, op2, stdata, tag;
    logic [4:0]  immx;
    logic        isimm, ill;
  } exp_t;

  function automatic dec_t mdecode(input logic [15:0] ins);
    dec_t d;
    int op = int'(ins[15:12]);
    d.legal = (op < 12) || (op == 15);
    d.src1  = (op < 12) && (op != 6);
    d.src2  = !ins[11] && (op inside {0, 3, 4, 5, 6, 7, 8, 10, 11});
    d.src3  = (op == 2);
    if (op == 5)                                    d.dest = 7;
    else if (op inside {0, 1, 3, 4, 6, 7, 8, 9, 10, 11}) d.dest = int'(ins[10:8]);
    else                                            d.dest = -1;
    return d;
  endfunction

  function automatic logic [15:0] enc(input int op, input int i, input int rd,
                                      input int rs1, input int lo5);
    return {4'(op), 1'(i), 3'(rd), 3'(rs1), 5'(lo5)};
  endfunction

  // One clock: drive inputs, check in_ready before the edge, outputs after it.
  task automatic cycle(input bit rn, input bit v, input logic [15:0] ins, input bit fl,
                       input bit wbv, input logic [2:0] wr,
                       input bit x_en, input bit x_ready, input logic [11:0] x_alu,
                       input logic [15:0] x_tag, input bit x_ill);
    dec_t d;
    exp_t e;
    bit   haz, rdy, acc;
    int   op;
    rst_n = rn; fif.in_valid = v; fif.in_instr = ins; fif.flush = fl;
    wb_valid = wbv; wb_rd = wr;
    #1;
    d   = mdecode(ins);
    op  = int'(ins[15:12]);
    haz = (d.src1 && pend_m[ins[7:5]] != 0) || (d.src2 && pend_m[ins[4:2]] != 0) ||
          (d.src3 && pend_m[ins[10:8]] != 0) || (d.dest >= 0 && pend_m[d.dest] == 3);
    rdy = rn && !fl && !haz;
    acc = v && rdy;
    check("in_ready", fif.in_ready, rdy);
    if (x_en) check("vec_ready", fif.in_ready, x_ready);
    e = '{alu: '0, op1: '0, op2: '0, stdata: '0, tag: NOP, immx: '0, isimm: 1'b0, ill: 1'b0};
    if (acc && d.legal && op != 15) begin
      e.alu    = 12'd1 << op;
      e.op1    = rf[ins[7:5]];
      e.op2    = rf[ins[4:2]];
      e.stdata = rf[ins[10:8]];
      e.immx   = ins[4:0];
      e.isimm  = ins[11] || op == 1 || op == 2;
      e.tag    = ins;
    end
    e.ill = acc && !d.legal;
    @(posedge clk);
    #1;
    check("alusignals", alusignals, e.alu);
    check("op1", op1, e.op1);
    check("op2", op2, e.op2);
    check("stdata", stdata, e.stdata);
    check("immx", immx, e.immx);
    check("isimmediate", isimmediate, e.isimm);
    check("instrout", instrout, e.tag);
    check("illegal", illegal, e.ill);
    if (x_en) begin
      check("vec_alu", alusignals, x_alu);
      check("vec_tag", instrout, x_tag);
      check("vec_illegal", illegal, x_ill);
    end
    if (!rn) begin
      for (int r = 0; r < 8; r++) pend_m[r] = 0;
    end else begin
      if (wbv && pend_m[wr] > 0) pend_m[wr]--;
      if (acc && d.legal && d.dest >= 0) pend_m[d.dest]++;
    end
  endtask

  typedef struct {
    bit          rn, v;
    logic [15:0] ins;
    bit          fl, wbv;
    logic [2:0]  wr;
    bit          x_ready;
    logic [11:0] x_alu;
    logic [15:0] x_tag;
    bit          x_ill;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit rn, input bit v, input logic [15:0] ins,
                              input bit fl, input bit wbv, input logic [2:0] wr,
                              input bit xr, input logic [11:0] xa,
                              input logic [15:0] xt, input bit xi);
    vt.push_back('{rn, v, ins, fl, wbv, wr, xr, xa, xt, xi});
  endfunction

  initial begin
    logic [15:0] a_i, or_i, sub_i, add2_i, ld_i, st_i, cmp1_i, cmp2_i, mov_i, mov5_i, rsv_i;
    int pend_list[$];

    for (int r = 0; r < 8; r++) rf[r] = 16'h1000 + 16'(r) * 16'h0111;
    for (int r = 0; r < 8; r++) pend_m[r] = 0;

    a_i    = enc(0, 0, 1, 2, 3 << 2);   // add r1,r2,r3
    or_i   = enc(7, 0, 4, 5, 6 << 2);   // or  r4,r5,r6
    sub_i  = enc(3, 0, 1, 2, 3 << 2);   // sub r1,r2,r3
    add2_i = enc(0, 0, 2, 1, 3 << 2);   // add r2,r1,r3
    ld_i   = enc(1, 0, 2, 1, 5);        // ld  r2,[r1+5] with I=0
    st_i   = enc(2, 1, 2, 1, 3);        // st  r2,[r1+3]
    cmp1_i = enc(5, 0, 0, 3, 4 << 2);   // cmp r3,r4
    cmp2_i = enc(5, 0, 0, 7, 4 << 2);   // cmp r7,r4
    mov_i  = enc(6, 1, 0, 0, 1);        // mov r0,#1
    mov5_i = enc(6, 0, 5, 0, 0);        // mov r5,r0
    rsv_i  = 16'hC000;

    add(0, 1, a_i,    0, 0, 0, 0, 12'h000, NOP,    0);
    add(0, 1, a_i,    0, 0, 0, 0, 12'h000, NOP,    0);
    add(1, 1, a_i,    0, 0, 0, 1, 12'h001, a_i,    0);
    add(1, 1, or_i,   0, 0, 0, 1, 12'h080, or_i,   0);
    add(1, 1, sub_i,  0, 0, 0, 1, 12'h008, sub_i,  0);
    add(1, 1, add2_i, 0, 0, 0, 0, 12'h000, NOP,    0);
    add(1, 1, add2_i, 0, 1, 1, 0, 12'h000, NOP,    0);
    add(1, 1, add2_i, 0, 1, 1, 0, 12'h000, NOP,    0);
    add(1, 1, add2_i, 0, 0, 0, 1, 12'h001, add2_i, 0);
    add(1, 1, ld_i,   0, 1, 4, 1, 12'h002, ld_i,   0);
    add(1, 0, NOP,    0, 1, 2, 1, 12'h000, NOP,    0);
    add(1, 0, NOP,    0, 1, 2, 1, 12'h000, NOP,    0);
    add(1, 1, st_i,   0, 0, 0, 1, 12'h004, st_i,   0);
    add(1, 1, cmp1_i, 0, 0, 0, 1, 12'h020, cmp1_i, 0);
    add(1, 1, cmp2_i, 0, 0, 0, 0, 12'h000, NOP,    0);
    add(1, 1, cmp2_i, 0, 1, 7, 0, 12'h000, NOP,    0);
    add(1, 1, cmp2_i, 0, 0, 0, 1, 12'h020, cmp2_i, 0);
    add(1, 0, NOP,    0, 1, 7, 1, 12'h000, NOP,    0);
    for (int k = 0; k < 3; k++) add(1, 1, mov_i, 0, 0, 0, 1, 12'h040, mov_i, 0);
    add(1, 1, mov_i,  0, 0, 0, 0, 12'h000, NOP,    0);
    add(1, 1, mov_i,  0, 1, 0, 0, 12'h000, NOP,    0);
    add(1, 1, mov_i,  0, 0, 0, 1, 12'h040, mov_i,  0);
    for (int k = 0; k < 4; k++) add(1, 0, NOP, 0, 1, 0, 1, 12'h000, NOP, 0);
    add(1, 1, mov5_i, 0, 0, 0, 1, 12'h040, mov5_i, 0);
    add(1, 1, rsv_i,  0, 0, 0, 1, 12'h000, NOP,    1);
    add(1, 0, NOP,    0, 0, 0, 1, 12'h000, NOP,    0);
    add(1, 1, a_i,    1, 0, 0, 0, 12'h000, NOP,    0);
    add(1, 1, NOP,    0, 0, 0, 1, 12'h000, NOP,    0);
    add(1, 1, a_i,    0, 0, 0, 1, 12'h001, a_i,    0);
    add(1, 1, add2_i, 0, 0, 0, 0, 12'h000, NOP,    0);
    add(0, 1, add2_i, 0, 0, 0, 0, 12'h000, NOP,    0);
    add(1, 1, add2_i, 0, 0, 0, 1, 12'h001, add2_i, 0);

    foreach (vt[i]) begin
      cycle(vt[i].rn, vt[i].v, vt[i].ins, vt[i].fl, vt[i].wbv, vt[i].wr,
            1'b1, vt[i].x_ready, vt[i].x_alu, vt[i].x_tag, vt[i].x_ill);
    end

    // Randomized traffic; writebacks only target registers with pending writes.
    for (int n = 0; n < 3000; n++) begin
      bit          rn, v, fl, wbv;
      logic [2:0]  wr;
      logic [15:0] ins;
      for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
      rn  = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 4) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      ins = 16'($urandom);
      pend_list.delete();
      for (int r = 0; r < 8; r++) if (pend_m[r] > 0) pend_list.push_back(r);
      wbv = 1'b0;
      wr  = 3'($urandom);
      if (pend_list.size() > 0 && $urandom_range(0, 1) == 1) begin
        wbv = 1'b1;
        wr  = 3'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
      end
      cycle(rn, v, ins, fl, wbv, wr, 1'b0, 1'b0, 12'h000, NOP, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
